verbus_multiport_memory: RTL and testbench
==========================================

VERBUS_MULTIPORT_MEMORY -- requirements
Module: verbus_multiport_memory

Interface
REQ-001 SHALL have parameter PORTS, default 2, meaning number of Verbus requester ports (legal 1..4).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of two).
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles inserted before ready (legal 0..15).
REQ-004 SHALL have parameter BASE_ADDRESS, default 32'h00000000, meaning byte address of word 0 (DEPTH*4 aligned).
REQ-005 SHALL have port: clk  input  1  single clock, rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: valid  input  PORTS  per-port request valid.
REQ-008 SHALL have port: address  input  PORTS x 32  per-port byte address.
REQ-009 SHALL have port: wstrobe  input  PORTS x 4  per-port byte-write enables; 0000 = read.
REQ-010 SHALL have port: wdata  input  PORTS x 32  per-port write data, byte lanes pre-replicated by requester.
REQ-011 SHALL have port: rdata  output  PORTS x 32  per-port read data, meaningful only while ready is high.
REQ-012 SHALL have port: ready  output  PORTS  per-port one-cycle completion pulse.
REQ-013 SHALL have port: error  output  PORTS  per-port out-of-range flag, valid with ready.

Function
REQ-014 SHALL be a single shared word array serving one transaction at a time.
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESPOND -> IDLE; IDLE -> RESPOND directly when WAIT_STATES = 0.
REQ-016 SHALL, in IDLE, grant the lowest-numbered valid port at or after the round-robin pointer, latching port index, address, wstrobe, wdata.
REQ-017 SHALL advance the round-robin pointer to granted index + 1 (mod PORTS) on each grant.
REQ-018 SHALL count exactly WAIT_STATES cycles in WAIT with a 4-bit down-counter.
REQ-019 SHALL, in RESPOND, assert ready only for the granted port for exactly one cycle; all other ready bits 0.
REQ-020 SHALL give latency from grant edge to ready = 1 + WAIT_STATES cycles; a requester holding valid from cycle T, granted at T, sees ready at T+1+WAIT_STATES.
REQ-021 SHALL require requesters to hold valid/address/wstrobe/wdata until ready; deassertion mid-transaction is ignored (latched values complete).
REQ-022 SHALL commit writes on the RESPOND edge, only byte lanes with wstrobe bit set, word index = address[log2(DEPTH)+1:2].
REQ-023 SHALL return rdata = full stored word (pre-write contents for writes) for reads; byte/half extraction is the requester's job.
REQ-024 SHALL flag error with ready, return rdata 0 and suppress writes when address is outside BASE_ADDRESS..BASE_ADDRESS+DEPTH*4-1.
REQ-025 SHALL ignore address[1:0] for word indexing (misaligned accesses hit the containing word).
REQ-026 SHALL return to IDLE after RESPOND and accept a new grant no earlier than the following cycle (one idle bubble).
REQ-027 SHALL drive rdata to 0 on all non-ready ports.

Reset
REQ-028 SHALL, on reset low, immediately force FSM to IDLE, counter 0, pointer 0, ready 0, error 0, rdata 0.
REQ-029 SHALL abandon an in-flight transaction on reset without writing memory; memory contents are not cleared.

Structure
REQ-030 SHALL take word_t and wstrobe_t from Verdata_pkg; FSM state enum and MAX_PORTS constant SHALL go in a new Vermem_pkg.
REQ-031 SHALL instantiate one sub-module verbus_rr_arbiter (PORTS-wide request vector, pointer, grant index, grant valid).

Verification
REQ-032 SHALL test: PORTS=1, WAIT_STATES=0, write 32'h00000096 wstrobe 1111 to 0x100, read 0x100 -> ready one cycle after each grant, rdata 32'h00000096.
REQ-033 SHALL test: write 32'h8C15F3E4, then wstrobe 0100 wdata 32'h96969696 at 0x102 -> readback 32'h8C96F3E4.
REQ-034 SHALL test: PORTS=2, both ports valid continuously -> grants alternate 0,1,0,1; each ready 2+WAIT_STATES cycles apart including the bubble.
REQ-035 SHALL test: WAIT_STATES=3 read -> ready exactly 4 cycles after grant, never earlier.
REQ-036 SHALL test: DEPTH=1024, BASE 0, read 0x00001000 -> ready with error 1, rdata 0; write there leaves word 0 unchanged.
REQ-037 SHALL test: reset asserted during WAIT of a write -> no ready, target word unchanged, next grant goes to port 0.

Source files
------------

// File: rtl/Verdata_pkg.sv
// Verbus data-path types shared by requesters and targets.
package Verdata_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wstrobe_t;

endpackage

// File: rtl/Vermem_pkg.sv
// Verbus memory target: FSM states, port limit and sizing helper.
package Vermem_pkg;

    localparam int MAX_PORTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESPOND
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/verbus_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr,
// wrapping around the port range.
module verbus_rr_arbiter
    import Vermem_pkg::*;
#(
    parameter int PORTS = 2,
    parameter int IW    = idx_width(PORTS)
)(
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_valid
);

    always_comb begin
        int best;
        int d;
        best      = PORTS;
        d         = 0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // distance from ptr, modulo PORTS; smallest distance wins
        for (int j = 0; j < PORTS; j++) begin
            d = j - int'(ptr);
            if (d < 0) d = d + PORTS;
            if (req[j] && d < best) begin
                best      = d;
                gnt_idx   = IW'(j);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/verbus_multiport_memory.sv
// Shared single-array Verbus memory serving one transaction at a time
// for up to MAX_PORTS requesters, with optional wait states.
module verbus_multiport_memory
    import Verdata_pkg::*;
    import Vermem_pkg::*;
#(
    parameter int          PORTS        = 2,
    parameter int          DEPTH        = 1024,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic     [PORTS-1:0] valid,
    input  word_t    [PORTS-1:0] address,
    input  wstrobe_t [PORTS-1:0] wstrobe,
    input  word_t    [PORTS-1:0] wdata,
    output word_t    [PORTS-1:0] rdata,
    output logic     [PORTS-1:0] ready,
    output logic     [PORTS-1:0] error
);

    localparam int         AW = $clog2(DEPTH);
    localparam int         IW = idx_width(PORTS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e        state, state_nx;
    logic [3:0]    cnt;
    logic [IW-1:0] ptr, gnt_idx, port_q;
    logic          gnt_valid;
    logic [AW-1:0] idx_q;
    word_t         data_q, sel_addr, sel_data, offset;
    wstrobe_t      strb_q, sel_strb;
    logic          hit_q, sel_hit;
    word_t         mem [DEPTH];

    verbus_rr_arbiter #(
        .PORTS(PORTS),
        .IW   (IW)
    ) u_arb (
        .req      (valid),
        .ptr      (ptr),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_strb = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (gnt_idx == IW'(j)) begin
                sel_addr = address[j];
                sel_data = wdata[j];
                sel_strb = wstrobe[j];
            end
        end
    end

    assign offset  = sel_addr - BASE_ADDRESS;
    assign sel_hit = (sel_addr >= BASE_ADDRESS) && (offset < 32'(DEPTH * 4));

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (gnt_valid) state_nx = (WS == 4'd0) ? ST_RESPOND : ST_WAIT;
            ST_WAIT:    if (cnt <= 4'd1) state_nx = ST_RESPOND;
            ST_RESPOND: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            port_q <= '0;
            idx_q  <= '0;
            strb_q <= '0;
            data_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && gnt_valid) begin
                port_q <= gnt_idx;
                idx_q  <= sel_addr[AW+1:2];
                strb_q <= sel_strb;
                data_q <= sel_data;
                hit_q  <= sel_hit;
                cnt    <= WS;
                ptr    <= (gnt_idx == IW'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Array is never reset; an aborted transaction never reaches RESPOND.
    always_ff @(posedge clk) begin
        if (state == ST_RESPOND && hit_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) mem[idx_q][b*8 +: 8] <= data_q[b*8 +: 8];
            end
        end
    end

    always_comb begin
        ready = '0;
        error = '0;
        rdata = '0;
        if (state == ST_RESPOND) begin
            for (int j = 0; j < PORTS; j++) begin
                if (port_q == IW'(j)) begin
                    ready[j] = 1'b1;
                    error[j] = ~hit_q;
                    rdata[j] = hit_q ? mem[idx_q] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_verbus_multiport_memory.sv
// Scoreboard bench: single-port zero-wait instance and two-port
// three-wait instance, checked against a word-level memory model.
module tb_verbus_multiport_memory;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        bit          chk;
        int          port;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [0:0]       a_valid = '0;
    logic [0:0][31:0] a_address = '0;
    logic [0:0][3:0]  a_wstrobe = '0;
    logic [0:0][31:0] a_wdata = '0;
    logic [0:0][31:0] a_rdata;
    logic [0:0]       a_ready;
    logic [0:0]       a_error;

    logic [1:0]       b_valid = '0;
    logic [1:0][31:0] b_address = '0;
    logic [1:0][3:0]  b_wstrobe = '0;
    logic [1:0][31:0] b_wdata = '0;
    logic [1:0][31:0] b_rdata;
    logic [1:0]       b_ready;
    logic [1:0]       b_error;

    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];
    exp_t        qa [$];
    exp_t        qb [$];

    verbus_multiport_memory #(
        .PORTS(1), .DEPTH(1024), .WAIT_STATES(0), .BASE_ADDRESS(32'h0)
    ) u_a (
        .clk(clk), .reset(rst_a), .valid(a_valid), .address(a_address),
        .wstrobe(a_wstrobe), .wdata(a_wdata), .rdata(a_rdata),
        .ready(a_ready), .error(a_error)
    );

    verbus_multiport_memory #(
        .PORTS(2), .DEPTH(1024), .WAIT_STATES(3), .BASE_ADDRESS(32'h0)
    ) u_b (
        .clk(clk), .reset(rst_b), .valid(b_valid), .address(b_address),
        .wstrobe(b_wstrobe), .wdata(b_wdata), .rdata(b_rdata),
        .ready(b_ready), .error(b_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected response for one access; updates the model for writes.
    function automatic exp_t predict(input bit on_b, input logic [31:0] ad,
                                     input logic [3:0] st, input logic [31:0] wd,
                                     input int port, input int cyc_exp);
        exp_t e;
        int idx;
        bit known;
        logic [31:0] w;
        e.port = port;
        e.cyc  = cyc_exp;
        e.err  = (ad >= 32'h1000);
        e.rd   = '0;
        e.chk  = 1'b1;
        if (!e.err) begin
            idx   = int'(ad[11:2]);
            known = on_b ? mdl_b.exists(idx) : mdl_a.exists(idx);
            w     = '0;
            if (known) w = on_b ? mdl_b[idx] : mdl_a[idx];
            e.rd  = w;
            e.chk = known;
            if (st != 4'h0 && (known || st == 4'hF)) begin
                for (int k = 0; k < 4; k++)
                    if (st[k]) w[k*8 +: 8] = wd[k*8 +: 8];
                if (on_b) mdl_b[idx] = w;
                else mdl_a[idx] = w;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (a_ready[0]) begin
            if (qa.size() == 0) begin
                chk("a_spurious_ready", 32'(a_ready), 32'h0);
            end else begin
                e = qa.pop_front();
                if (e.chk) chk("a_rdata", a_rdata[0], e.rd);
                chk("a_error", 32'(a_error[0]), 32'(e.err));
                chk("a_latency", cyc, e.cyc);
            end
        end else begin
            chk("a_idle_rdata", a_rdata[0], 32'h0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_ready != 2'b00) begin
            chk("b_ready_onehot", $countones(b_ready), 32'd1);
        end
        for (int p = 0; p < 2; p++) begin
            if (b_ready[p]) begin
                if (qb.size() == 0) begin
                    chk("b_spurious_ready", 32'(b_ready), 32'h0);
                end else begin
                    e = qb.pop_front();
                    chk("b_port", p, e.port);
                    if (e.chk) chk("b_rdata", b_rdata[p], e.rd);
                    chk("b_error", 32'(b_error[p]), 32'(e.err));
                    chk("b_latency", cyc, e.cyc);
                end
            end else begin
                chk("b_idle_rdata", b_rdata[p], 32'h0);
            end
        end
    end

    task automatic wait_a(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = a_ready[0];
        end
    endtask

    task automatic wait_b(input int p, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = b_ready[p];
        end
    endtask

    task automatic a_xact(input logic [31:0] ad, input logic [3:0] st, input logic [31:0] wd);
        bit seen;
        @(posedge clk);
        #1;
        a_valid[0]   = 1'b1;
        a_address[0] = ad;
        a_wstrobe[0] = st;
        a_wdata[0]   = wd;
        qa.push_back(predict(1'b0, ad, st, wd, 0, cyc + 1));
        wait_a(seen);
        chk("a_done", 32'(seen), 32'h1);
        a_valid[0] = 1'b0;
    endtask

    task automatic b_xact(input int p, input logic [31:0] ad, input logic [3:0] st,
                          input logic [31:0] wd);
        bit seen;
        @(posedge clk);
        #1;
        b_valid[p]   = 1'b1;
        b_address[p] = ad;
        b_wstrobe[p] = st;
        b_wdata[p]   = wd;
        qb.push_back(predict(1'b1, ad, st, wd, p, cyc + 4));
        wait_b(p, seen);
        chk("b_done", 32'(seen), 32'h1);
        b_valid[p] = 1'b0;
    endtask

    task automatic arb_port(input int p, input logic [31:0] nxt);
        bit seen;
        wait_b(p, seen);
        chk("arb_first", 32'(seen), 32'h1);
        b_address[p] = nxt;
        wait_b(p, seen);
        chk("arb_second", 32'(seen), 32'h1);
        b_valid[p] = 1'b0;
    endtask

    initial begin
        int n;
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        chk("rst_a_error", 32'(a_error), 32'h0);
        chk("rst_b_ready", 32'(b_ready), 32'h0);
        chk("rst_b_error", 32'(b_error), 32'h0);
        chk("rst_b_rdata1", b_rdata[1], 32'h0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        a_xact(32'h100, 4'hF, 32'h0000_0096);
        a_xact(32'h100, 4'h0, 32'h0);
        a_xact(32'h100, 4'hF, 32'h8C15_F3E4);
        a_xact(32'h102, 4'b0100, 32'h9696_9696);
        a_xact(32'h100, 4'h0, 32'h0);
        a_xact(32'h103, 4'h0, 32'h0);
        a_xact(32'h000, 4'hF, 32'h1122_3344);
        a_xact(32'h1000, 4'h0, 32'h0);
        a_xact(32'h1000, 4'hF, 32'hDEAD_BEEF);
        a_xact(32'h000, 4'h0, 32'h0);

        b_xact(0, 32'h100, 4'hF, 32'h0000_A5A5);
        b_xact(1, 32'h100, 4'h0, 32'h0);
        b_xact(1, 32'h104, 4'hF, 32'h1234_5678);
        b_xact(0, 32'h200, 4'hF, 32'hCAFE_F00D);

        // Write abandoned by reset mid-wait; model left untouched.
        @(posedge clk);
        #1;
        b_valid[0]   = 1'b1;
        b_address[0] = 32'h100;
        b_wstrobe[0] = 4'hF;
        b_wdata[0]   = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        rst_b   = 1'b0;
        b_valid = '0;
        #1;
        chk("midrst_ready", 32'(b_ready), 32'h0);
        chk("midrst_error", 32'(b_error), 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (6) @(negedge clk);

        // Both ports held valid: grants alternate from port 0.
        @(posedge clk);
        #1;
        n = cyc;
        b_wstrobe = '0;
        b_wdata   = '0;
        b_address[0] = 32'h100;
        b_address[1] = 32'h200;
        b_valid = 2'b11;
        qb.push_back(predict(1'b1, 32'h100, 4'h0, 32'h0, 0, n + 4));
        qb.push_back(predict(1'b1, 32'h200, 4'h0, 32'h0, 1, n + 9));
        qb.push_back(predict(1'b1, 32'h104, 4'h0, 32'h0, 0, n + 14));
        qb.push_back(predict(1'b1, 32'h1000, 4'h0, 32'h0, 1, n + 19));
        fork
            arb_port(0, 32'h104);
            arb_port(1, 32'h1000);
        join

        repeat (8) @(negedge clk);
        chk("qa_drained", qa.size(), 32'h0);
        chk("qb_drained", qb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
